fpga_config_loader: RTL and testbench

Configuration controller for the fabric (9 logic tiles × 33 config bits, 13 switch boxes × 16 bits).
- Accepts a byte-wide bitstream over a valid/ready handshake.
- Checks a sync byte, then serialises the payload into the fabric's shadow scan chain, LSB first.
- Verifies an XOR checksum.
- On success, pulses a commit so every config register updates at once, then enables the fabric.
- Sits between the external loader interface and the fabric top level.

---
 rtl/fpga_cfg_pkg.sv | 33 +++
 rtl/cfg_byte_serializer.sv | 41 ++++
 rtl/fpga_config_loader.sv | 164 ++++++++++++++++
 tb/tb_fpga_config_loader.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared definitions for the fabric configuration loader.
//   - fabric geometry (logic tiles, switch boxes, bits per element) and the
//     derived shadow-chain length / payload byte count
//   - sync byte, error codes, loader state encoding
package fpga_cfg_pkg;

    localparam int NUM_TILES  = 9;
    localparam int TILE_BITS  = 33;
    localparam int NUM_SBOXES = 13;
    localparam int SBOX_BITS  = 16;

    localparam int CHAIN_LEN  = NUM_TILES * TILE_BITS + NUM_SBOXES * SBOX_BITS;
    localparam int NUM_BYTES  = (CHAIN_LEN + 7) / 8;
    // Bits of the final payload byte that actually reach the chain.
    localparam int LAST_BITS  = CHAIN_LEN - 8 * (NUM_BYTES - 1);
    localparam int BYTE_CNT_W = $clog2(NUM_BYTES + 1);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_SYNC     = 2'b01;
    localparam logic [1:0] ERR_CHECKSUM = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/cfg_byte_serializer.sv
// cfg_byte_serializer: turns one byte into up to eight serial bits, LSB first.
// Ports:
//   clock, reset   - system clock, async active-high reset
//   load           - capture data/nbits (only issued while empty)
//   data           - byte to serialise
//   nbits          - number of bits to emit (1..8); the rest are dropped
//   empty          - no bits left; a new byte may be loaded
//   sbit           - current serial bit (valid while shift is high)
//   shift          - a bit is being presented this cycle
module cfg_byte_serializer (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    input  logic [3:0] nbits,
    output logic       empty,
    output logic       sbit,
    output logic       shift
);

    logic [7:0] shreg;
    logic [3:0] remaining;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg     <= 8'h00;
            remaining <= 4'd0;
        end else if (load) begin
            shreg     <= data;
            remaining <= nbits;
        end else if (remaining != 4'd0) begin
            shreg     <= {1'b0, shreg[7:1]};
            remaining <= remaining - 4'd1;
        end
    end

    assign empty = (remaining == 4'd0);
    assign shift = (remaining != 4'd0);
    assign sbit  = shreg[0];

endmodule

// File: rtl/fpga_config_loader.sv
// fpga_config_loader: receives a byte bitstream (sync byte, payload, XOR
// checksum), shifts the payload into the fabric shadow chain LSB first,
// and commits it to the live config registers when the checksum matches.
// Ports:
//   clock, reset            - system clock, async active-high reset
//   start                   - begin a load (honoured in IDLE/DONE/ERROR)
//   in_data/in_valid/in_ready - byte input; transfer when in_valid && in_ready
//   cfg_bit/cfg_shift       - serial data + shift enable to the shadow chain
//   cfg_commit              - one-cycle shadow-to-live copy pulse
//   busy/done/error         - status; err_code gives the error cause
//   fabric_en               - fabric enable, set the cycle after commit
// Handshake: a byte moves on any cycle with in_valid && in_ready; in_ready
// is a function of registered state only, never of in_valid.
module fpga_config_loader
    import fpga_cfg_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       cfg_bit,
    output logic       cfg_shift,
    output logic       cfg_commit,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    output logic       fabric_en
);

    state_t                  state, state_next;
    logic [BYTE_CNT_W-1:0]   byte_cnt;
    logic [7:0]              checksum;
    logic [1:0]              err_q;
    logic                    fen_q;
    logic                    commit_q;

    logic                    xfer;
    logic                    start_ok;
    logic                    last_sent;
    logic                    ser_load;
    logic                    ser_empty;
    logic [3:0]              ser_nbits;
    logic                    go_commit;
    logic                    go_err_sync;
    logic                    go_err_cks;

    assign xfer      = in_valid && in_ready;
    assign last_sent = (byte_cnt == BYTE_CNT_W'(NUM_BYTES));
    assign ser_load  = (state == ST_LOAD) && xfer;
    // The final byte carries only the chain's tail; its padding is not shifted.
    assign ser_nbits = (byte_cnt == BYTE_CNT_W'(NUM_BYTES - 1)) ? 4'(LAST_BITS) : 4'd8;

    cfg_byte_serializer u_ser (
        .clock (clock),
        .reset (reset),
        .load  (ser_load),
        .data  (in_data),
        .nbits (ser_nbits),
        .empty (ser_empty),
        .sbit  (cfg_bit),
        .shift (cfg_shift)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        start_ok    = 1'b0;
        go_commit   = 1'b0;
        go_err_sync = 1'b0;
        go_err_cks  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    start_ok   = 1'b1;
                    state_next = ST_SYNC;
                end
            end
            ST_SYNC: begin
                in_ready = 1'b1;
                if (xfer) begin
                    if (in_data == SYNC_BYTE) begin
                        state_next = ST_LOAD;
                    end else begin
                        go_err_sync = 1'b1;
                        state_next  = ST_ERROR;
                    end
                end
            end
            ST_LOAD: begin
                in_ready = ser_empty && !last_sent;
                if (last_sent && ser_empty) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                in_ready = 1'b1;
                if (xfer) begin
                    if (in_data == checksum) begin
                        go_commit  = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        go_err_cks = 1'b1;
                        state_next = ST_ERROR;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_cnt <= '0;
            checksum <= 8'h00;
            err_q    <= ERR_NONE;
            fen_q    <= 1'b0;
            commit_q <= 1'b0;
        end else begin
            // Commit is registered so it lands in the first DONE cycle.
            commit_q <= go_commit;
            if (start_ok) begin
                byte_cnt <= '0;
                checksum <= 8'h00;
                err_q    <= ERR_NONE;
                fen_q    <= 1'b0;
            end else begin
                if (ser_load) begin
                    byte_cnt <= BYTE_CNT_W'(byte_cnt + 1'b1);
                    checksum <= checksum ^ in_data;
                end
                if (go_err_sync) begin
                    err_q <= ERR_SYNC;
                end
                if (go_err_cks) begin
                    err_q <= ERR_CHECKSUM;
                end
                if (commit_q) begin
                    fen_q <= 1'b1;
                end
            end
        end
    end

    assign cfg_commit = commit_q;
    assign busy       = (state == ST_SYNC) || (state == ST_LOAD) || (state == ST_CHECK);
    assign done       = (state == ST_DONE);
    assign error      = (state == ST_ERROR);
    assign err_code   = err_q;
    assign fabric_en  = fen_q;

endmodule

// File: tb/tb_fpga_config_loader.sv
module tb_fpga_config_loader;
  import fpga_cfg_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       cfg_bit;
  logic       cfg_shift;
  logic       cfg_commit;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;
  logic       fabric_en;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] pay [NUM_BYTES];

  // monitor counters, written only by the monitor process
  int shift_cnt    = 0;
  int ones_cnt     = 0;
  int last_one_idx = -1;
  int commit_cnt   = 0;
  int overlap_cnt  = 0;

  // snapshots taken by tests
  int base_shift, base_ones, base_commit, base_overlap;

  fpga_config_loader dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cfg_bit    (cfg_bit),
    .cfg_shift  (cfg_shift),
    .cfg_commit (cfg_commit),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .fabric_en  (fabric_en)
  );

  // clock / reset block
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (cfg_shift) begin
      if (cfg_bit) begin
        ones_cnt     = ones_cnt + 1;
        last_one_idx = shift_cnt;
      end
      shift_cnt = shift_cnt + 1;
    end
    if (cfg_commit) commit_cnt = commit_cnt + 1;
    if (cfg_shift && (in_ready || cfg_commit)) overlap_cnt = overlap_cnt + 1;
  end

  task at_neg();
    @(negedge clock);
    #1;
  endtask

  task snap();
    base_shift   = shift_cnt;
    base_ones    = ones_cnt;
    base_commit  = commit_cnt;
    base_overlap = overlap_cnt;
  endtask

  task pulse_start();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int waited;
    int gap;
    gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    repeat (gap) begin
      @(posedge clock);
      #1;
    end
    waited   = 0;
    in_data  = b;
    in_valid = 1'b1;
    at_neg();
    while (!in_ready && waited < 200) begin
      at_neg();
      waited++;
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL handshake_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  function automatic logic [7:0] pay_xor();
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < NUM_BYTES; i++) x = x ^ pay[i];
    return x;
  endfunction

  function automatic int pay_ones();
    int c;
    logic [7:0] lastb;
    c = 0;
    for (int i = 0; i < NUM_BYTES - 1; i++) c += $countones(pay[i]);
    lastb = pay[NUM_BYTES-1];
    for (int b = 0; b < LAST_BITS; b++) c += int'(lastb[b]);
    return c;
  endfunction

  // start, sync byte, payload from pay[], then checksum byte
  task automatic run_load(input logic [7:0] cks, input int max_gap, input bit hold_start);
    pulse_start();
    send_byte(SYNC_BYTE, max_gap);
    if (hold_start) start = 1'b1;
    for (int i = 0; i < NUM_BYTES; i++) send_byte(pay[i], max_gap);
    start = 1'b0;
    send_byte(cks, max_gap);
  endtask

  // checks the two cycles following a good checksum byte
  task automatic check_commit(input string tag, input int exp_ones);
    at_neg();
    n_checks++;
    if (cfg_commit !== 1'b1 || done !== 1'b1 || fabric_en !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_commit_cycle: commit=%0b done=%0b fabric_en=%0b, required 1 1 0", tag, cfg_commit, done, fabric_en);
    end
    at_neg();
    n_checks++;
    if (cfg_commit !== 1'b0 || fabric_en !== 1'b1 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_enable: commit=%0b fabric_en=%0b done=%0b, required 0 1 1", tag, cfg_commit, fabric_en, done);
    end
    n_checks++;
    if (shift_cnt - base_shift !== CHAIN_LEN) begin
      n_fail++;
      $display("FAIL %s_shift_count: got %0d, required %0d", tag, shift_cnt - base_shift, CHAIN_LEN);
    end
    n_checks++;
    if (commit_cnt - base_commit !== 1) begin
      n_fail++;
      $display("FAIL %s_commit_count: got %0d, required 1", tag, commit_cnt - base_commit);
    end
    n_checks++;
    if (ones_cnt - base_ones !== exp_ones) begin
      n_fail++;
      $display("FAIL %s_ones: got %0d, required %0d", tag, ones_cnt - base_ones, exp_ones);
    end
    n_checks++;
    if (overlap_cnt - base_overlap !== 0) begin
      n_fail++;
      $display("FAIL %s_overlap: got %0d cycles with shift+ready/commit, required 0", tag, overlap_cnt - base_overlap);
    end
  endtask

  task test_reset();
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clock);
    at_neg();
    n_checks++;
    if ({in_ready, cfg_bit, cfg_shift, cfg_commit, busy, done, error, err_code, fabric_en} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required all zero",
               {in_ready, cfg_bit, cfg_shift, cfg_commit, busy, done, error, err_code, fabric_en});
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    at_neg();
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%0b in_ready=%0b, required 0 0", busy, in_ready);
    end
  endtask

  task test_good_load();
    for (int i = 0; i < NUM_BYTES; i++) pay[i] = 8'h00;
    snap();
    pulse_start();
    at_neg();
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL sync_state: busy=%0b in_ready=%0b, required 1 1", busy, in_ready);
    end
    @(posedge clock);
    #1;
    send_byte(SYNC_BYTE, 0);
    for (int i = 0; i < NUM_BYTES; i++) send_byte(pay[i], 0);
    send_byte(8'h00, 0);
    check_commit("good", 0);
  endtask

  task test_bit_order();
    for (int i = 0; i < NUM_BYTES; i++) pay[i] = 8'h00;
    pay[0] = 8'h01;
    snap();
    run_load(8'h01, 0, 1'b0);
    check_commit("bitorder", 1);
    n_checks++;
    if (last_one_idx !== base_shift) begin
      n_fail++;
      $display("FAIL bitorder_position: one at shift %0d, required %0d", last_one_idx - base_shift, 0);
    end
  endtask

  task test_reconfigure();
    for (int i = 0; i < NUM_BYTES; i++) pay[i] = 8'($urandom);
    snap();
    pulse_start();
    at_neg();
    n_checks++;
    if (fabric_en !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reconfig_start: fabric_en=%0b done=%0b busy=%0b, required 0 0 1", fabric_en, done, busy);
    end
    @(posedge clock);
    #1;
    send_byte(SYNC_BYTE, 0);
    for (int i = 0; i < NUM_BYTES; i++) send_byte(pay[i], 0);
    send_byte(pay_xor(), 0);
    check_commit("reconfig", pay_ones());
  endtask

  task test_bad_sync();
    snap();
    pulse_start();
    send_byte(8'h5A, 0);
    at_neg();
    n_checks++;
    if (error !== 1'b1 || err_code !== 2'b01 || in_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_sync_status: error=%0b err_code=%b in_ready=%0b busy=%0b, required 1 01 0 0",
               error, err_code, in_ready, busy);
    end
    n_checks++;
    if (shift_cnt - base_shift !== 0 || fabric_en !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_sync_shifts: shifts=%0d fabric_en=%0b, required 0 0", shift_cnt - base_shift, fabric_en);
    end
  endtask

  task test_bad_checksum();
    for (int i = 0; i < NUM_BYTES; i++) pay[i] = 8'hFF;
    snap();
    pulse_start();
    at_neg();
    n_checks++;
    if (err_code !== 2'b00 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear_on_start: err_code=%b error=%0b, required 00 0", err_code, error);
    end
    @(posedge clock);
    #1;
    send_byte(SYNC_BYTE, 0);
    for (int i = 0; i < NUM_BYTES; i++) send_byte(pay[i], 0);
    send_byte(8'hFF, 0);
    repeat (3) at_neg();
    n_checks++;
    if (error !== 1'b1 || err_code !== 2'b10 || fabric_en !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_cks_status: error=%0b err_code=%b fabric_en=%0b done=%0b, required 1 10 0 0",
               error, err_code, fabric_en, done);
    end
    n_checks++;
    if (commit_cnt - base_commit !== 0) begin
      n_fail++;
      $display("FAIL bad_cks_commit: got %0d commits, required 0", commit_cnt - base_commit);
    end
    n_checks++;
    if (shift_cnt - base_shift !== CHAIN_LEN || ones_cnt - base_ones !== CHAIN_LEN) begin
      n_fail++;
      $display("FAIL bad_cks_shifts: shifts=%0d ones=%0d, required %0d %0d",
               shift_cnt - base_shift, ones_cnt - base_ones, CHAIN_LEN, CHAIN_LEN);
    end
  endtask

  task test_back_to_back_gaps();
    for (int i = 0; i < NUM_BYTES; i++) pay[i] = 8'($urandom);
    snap();
    // start held high through the payload must be ignored
    run_load(pay_xor(), 3, 1'b1);
    check_commit("gaps", pay_ones());
  endtask

  task test_reset_midload();
    for (int i = 0; i < NUM_BYTES; i++) pay[i] = 8'($urandom);
    pulse_start();
    send_byte(SYNC_BYTE, 0);
    for (int i = 0; i < 20; i++) send_byte(pay[i], 0);
    snap();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, cfg_shift, cfg_commit, busy, done, error, err_code, fabric_en} !== 9'b0) begin
      n_fail++;
      $display("FAIL midload_reset: got %b, required all zero",
               {in_ready, cfg_shift, cfg_commit, busy, done, error, err_code, fabric_en});
    end
    repeat (3) at_neg();
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (20) at_neg();
    n_checks++;
    if (commit_cnt - base_commit !== 0 || shift_cnt - base_shift !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midload_after: commits=%0d shifts=%0d busy=%0b, required 0 0 0",
               commit_cnt - base_commit, shift_cnt - base_shift, busy);
    end
    // a fresh load from IDLE still works after the abort
    for (int i = 0; i < NUM_BYTES; i++) pay[i] = 8'($urandom);
    snap();
    run_load(pay_xor(), 0, 1'b0);
    check_commit("post_reset", pay_ones());
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bit_order();
    test_reconfigure();
    test_bad_sync();
    test_bad_checksum();
    test_back_to_back_gaps();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
